// File: rtl/baud_nco_gen_pkg.sv
// Shared UART rate defaults and the phase-increment helper used for INC_DEFAULT
// and for building software-side baud tables.
package baud_nco_gen_pkg;

  localparam int unsigned SYS_CLK_DEFAULT    = 100_000_000;
  localparam int unsigned BAUD_DEFAULT       = 9600;
  localparam int unsigned OVERSAMPLE_DEFAULT = 8;

  // floor(baud * os * 2^acc_w / sys_clk), evaluated in 64-bit arithmetic.
  function automatic longint unsigned baud_inc(input longint unsigned sys_clk,
                                               input longint unsigned baud,
                                               input longint unsigned os,
                                               input int unsigned     acc_w);
    return ((baud * os) << acc_w) / sys_clk;
  endfunction

endpackage

// File: rtl/baud_phase_acc.sv
// Phase accumulator: increment register, wrapping accumulator and carry out.
// Restart forces half phase and beats accumulation; inc_load is independent of both.
module baud_phase_acc #(
  parameter int unsigned           ACC_W   = 32,
  parameter logic [ACC_W-1:0]      INC_RST = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             restart,
  input  logic             inc_load,
  input  logic [ACC_W-1:0] inc_in,
  output logic [ACC_W-1:0] inc_cur,
  output logic             carry
);

  localparam logic [ACC_W-1:0] HALF_PHASE = {1'b1, {(ACC_W-1){1'b0}}};

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] inc_reg;
  logic [ACC_W:0]   sum;

  assign sum     = {1'b0, acc} + {1'b0, inc_reg};
  assign carry   = en & ~restart & sum[ACC_W];
  assign inc_cur = inc_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc     <= '0;
      inc_reg <= INC_RST;
    end else begin
      if (restart) begin
        acc <= HALF_PHASE;
      end else if (en) begin
        acc <= sum[ACC_W-1:0];
      end
      // Loading never touches acc, so a rate change has no phase glitch.
      if (inc_load) begin
        inc_reg <= inc_in;
      end
    end
  end

endmodule

// File: rtl/baud_nco_gen.sv
// Fractional baud-rate generator: NCO carry drives the oversample tick, and an
// oversample counter decodes the bit tick and mid-bit sample tick.
module baud_nco_gen
  import baud_nco_gen_pkg::*;
#(
  parameter int unsigned     SYS_CLK     = SYS_CLK_DEFAULT,
  parameter int unsigned     BAUD        = BAUD_DEFAULT,
  parameter int unsigned     OVERSAMPLE  = OVERSAMPLE_DEFAULT,
  parameter int unsigned     ACC_W       = 32,
  parameter longint unsigned INC_DEFAULT = baud_inc(64'(SYS_CLK), 64'(BAUD),
                                                    64'(OVERSAMPLE), ACC_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             restart,
  input  logic             inc_load,
  input  logic [ACC_W-1:0] inc_in,
  output logic [ACC_W-1:0] inc_cur,
  output logic             os_tick,
  output logic             bit_tick,
  output logic             mid_tick
);

  localparam int unsigned      CNT_W    = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [ACC_W-1:0] INC_RST  = ACC_W'(INC_DEFAULT);

  logic             carry;
  logic [CNT_W-1:0] os_cnt;

  baud_phase_acc #(
    .ACC_W   (ACC_W),
    .INC_RST (INC_RST)
  ) u_phase_acc (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .restart  (restart),
    .inc_load (inc_load),
    .inc_in   (inc_in),
    .inc_cur  (inc_cur),
    .carry    (carry)
  );

  // carry is already gated by en and restart, so the decode only needs carry.
  always_ff @(posedge clk) begin
    if (!rst) begin
      os_cnt   <= '0;
      os_tick  <= 1'b0;
      bit_tick <= 1'b0;
      mid_tick <= 1'b0;
    end else begin
      os_tick  <= carry;
      bit_tick <= carry && (os_cnt == CNT_LAST);
      mid_tick <= carry && (os_cnt == CNT_MID);
      if (restart) begin
        os_cnt <= '0;
      end else if (carry) begin
        os_cnt <= (os_cnt == CNT_LAST) ? '0 : os_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_baud_nco_gen.sv
// Self-checking bench for baud_nco_gen: an 8-bit instance against a phase/tick-count
// model, and a default-parameter instance against closed-form tick positions.
module tb_baud_nco_gen;

  localparam int     OS        = 8;
  localparam int     INC8_DEF  = (9600 * 8 * 256) / 1_000_000;
  localparam longint INC32_DEF = 3298534;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b0, en = 1'b0, restart = 1'b0, inc_load = 1'b0;
  logic [7:0]  inc_in = '0;
  logic [7:0]  inc_cur;
  logic        os_tick, bit_tick, mid_tick;

  logic        en32 = 1'b1, restart32 = 1'b0, inc_load32 = 1'b0;
  logic [31:0] inc_in32 = '0;
  logic [31:0] inc_cur32;
  logic        os32, bit32, mid32;

  int vectors = 0;
  int miscompares = 0;

  int   m_acc, m_inc, m_ticks, exp_inc;
  logic exp_os, exp_bit, exp_mid;
  logic [31:0] exp_q[$];

  baud_nco_gen #(
    .SYS_CLK(1_000_000), .BAUD(9600), .OVERSAMPLE(8), .ACC_W(8)
  ) dut8 (
    .clk(clk), .rst(rst), .en(en), .restart(restart), .inc_load(inc_load),
    .inc_in(inc_in), .inc_cur(inc_cur), .os_tick(os_tick), .bit_tick(bit_tick),
    .mid_tick(mid_tick)
  );

  baud_nco_gen dut32 (
    .clk(clk), .rst(rst), .en(en32), .restart(restart32), .inc_load(inc_load32),
    .inc_in(inc_in32), .inc_cur(inc_cur32), .os_tick(os32), .bit_tick(bit32),
    .mid_tick(mid32)
  );

  // Advance one edge; the model treats phase as a number on a 256-unit circle and
  // numbers each tick since reset/restart (bit = every 8th, mid = 4th of each 8).
  task automatic cycle();
    @(posedge clk);
    exp_os = 1'b0; exp_bit = 1'b0; exp_mid = 1'b0;
    if (!rst) begin
      m_acc = 0; m_inc = INC8_DEF; m_ticks = 0;
    end else begin
      if (restart) begin
        m_acc = 128; m_ticks = 0;
      end else if (en) begin
        if (m_acc + m_inc >= 256) begin
          m_ticks++;
          exp_os  = 1'b1;
          exp_bit = (m_ticks % OS == 0);
          exp_mid = (m_ticks % OS == OS / 2);
        end
        m_acc = (m_acc + m_inc) % 256;
      end
      if (inc_load) m_inc = int'(inc_in);
    end
    exp_inc = m_inc;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b1; inc_load = 1'b1; inc_in = 8'd200; restart = 1'b1;
    repeat (3) cycle();
    vectors++;
    if ({os_tick, bit_tick, mid_tick} !== 3'b000 || inc_cur !== 8'(INC8_DEF)) begin
      miscompares++;
      $display("FAIL reset8: got ticks=%b inc=%0d, want 000 inc=%0d",
               {os_tick, bit_tick, mid_tick}, inc_cur, INC8_DEF);
    end
    vectors++;
    if ({os32, bit32, mid32} !== 3'b000 || inc_cur32 !== 32'(INC32_DEF)) begin
      miscompares++;
      $display("FAIL reset32: got ticks=%b inc=%0d, want 000 inc=%0d",
               {os32, bit32, mid32}, inc_cur32, INC32_DEF);
    end
    inc_load = 1'b0; restart = 1'b0;
  endtask

  task automatic test_default_rate();
    int edge_n, prev, k;
    logic [31:0] want;
    prev = 0; k = 0;
    for (int t = 1; t <= 4; t++)
      exp_q.push_back(32'((longint'(t) * (64'd1 << 32) + INC32_DEF - 1) / INC32_DEF));
    rst = 1'b1;
    for (edge_n = 1; edge_n <= 5300; edge_n++) begin
      cycle();
      vectors++;
      if ({os_tick, bit_tick, mid_tick} !== {exp_os, exp_bit, exp_mid} || inc_cur !== exp_inc[7:0]) begin
        miscompares++;
        $display("FAIL default_bg8 edge %0d: got %b inc=%0d, want %b inc=%0d", edge_n,
                 {os_tick, bit_tick, mid_tick}, inc_cur, {exp_os, exp_bit, exp_mid}, exp_inc);
      end
      if (os32 === 1'b1) begin
        k++;
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL default_extra: unexpected tick at edge %0d", edge_n);
        end else begin
          want = exp_q.pop_front();
          if (32'(edge_n) !== want) begin
            miscompares++;
            $display("FAIL default_pos tick %0d: got edge %0d, want %0d", k, edge_n, want);
          end
        end
        if (prev != 0) begin
          vectors++;
          if (edge_n - prev != 1302 && edge_n - prev != 1303) begin
            miscompares++;
            $display("FAIL default_interval: got %0d, want 1302 or 1303", edge_n - prev);
          end
        end
        vectors++;
        if (mid32 !== (k == 4) || bit32 !== 1'b0) begin
          miscompares++;
          $display("FAIL default_decode tick %0d: got mid=%b bit=%b, want mid=%b bit=0",
                   k, mid32, bit32, (k == 4));
        end
        prev = edge_n;
      end
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL default_missing: got %0d ticks, want 4", k);
      exp_q.delete();
    end
  endtask

  task automatic test_rate64();
    int n_os, n_bit, n_mid, last_os, last_bit, last_mid;
    n_os = 0; n_bit = 0; n_mid = 0; last_os = -1; last_bit = 0; last_mid = 0;
    inc_in = 8'd64; inc_load = 1'b1;
    cycle();
    inc_load = 1'b0;
    vectors++;
    if (inc_cur !== 8'd64) begin
      miscompares++;
      $display("FAIL rate64_inc: got %0d, want 64", inc_cur);
    end
    for (int c = 0; c < 64; c++) begin
      cycle();
      vectors++;
      if ({os_tick, bit_tick, mid_tick} !== {exp_os, exp_bit, exp_mid} || inc_cur !== exp_inc[7:0]) begin
        miscompares++;
        $display("FAIL rate64 cyc %0d: got %b inc=%0d, want %b inc=%0d", c,
                 {os_tick, bit_tick, mid_tick}, inc_cur, {exp_os, exp_bit, exp_mid}, exp_inc);
      end
      if (os_tick) begin
        if (last_os >= 0) begin
          vectors++;
          if (c - last_os != 4) begin
            miscompares++;
            $display("FAIL rate64_interval: got %0d, want 4", c - last_os);
          end
        end
        last_os = c; n_os++;
      end
      if (bit_tick) begin n_bit++; last_bit = c; end
      if (mid_tick) begin n_mid++; last_mid = c; end
    end
    vectors++;
    if (n_os != 16 || n_bit != 2 || n_mid != 2) begin
      miscompares++;
      $display("FAIL rate64_counts: got os=%0d bit=%0d mid=%0d, want 16 2 2", n_os, n_bit, n_mid);
    end
    vectors++;
    if (last_bit - last_mid != 16 && last_mid - last_bit != 16) begin
      miscompares++;
      $display("FAIL rate64_mid_offset: got %0d, want 16", last_bit - last_mid);
    end
  endtask

  task automatic test_rate96();
    int gaps[$];
    int last, sum9;
    last = -1;
    inc_in = 8'd96; inc_load = 1'b1;
    cycle();
    inc_load = 1'b0;
    for (int c = 0; c < 72; c++) begin
      cycle();
      vectors++;
      if ({os_tick, bit_tick, mid_tick} !== {exp_os, exp_bit, exp_mid} || inc_cur !== exp_inc[7:0]) begin
        miscompares++;
        $display("FAIL rate96 cyc %0d: got %b inc=%0d, want %b inc=%0d", c,
                 {os_tick, bit_tick, mid_tick}, inc_cur, {exp_os, exp_bit, exp_mid}, exp_inc);
      end
      if (os_tick) begin
        if (last >= 0) gaps.push_back(c - last);
        last = c;
      end
    end
    vectors++;
    if (gaps.size() != 26) begin
      miscompares++;
      $display("FAIL rate96_count: got %0d ticks, want 27", gaps.size() + 1);
    end
    for (int i = 0; i < gaps.size(); i++) begin
      vectors++;
      if (gaps[i] != 2 && gaps[i] != 3) begin
        miscompares++;
        $display("FAIL rate96_gap %0d: got %0d, want 2 or 3", i, gaps[i]);
      end
    end
    if (gaps.size() >= 9) begin
      sum9 = 0;
      for (int i = 0; i < 9; i++) sum9 += gaps[i];
      vectors++;
      if (sum9 != 24) begin
        miscompares++;
        $display("FAIL rate96_span: got %0d cycles per 9 ticks, want 24", sum9);
      end
    end
  endtask

  task automatic test_restart();
    int n, first;
    n = 0; first = -1;
    inc_in = 8'd64; inc_load = 1'b1;
    cycle();
    inc_load = 1'b0;
    repeat (13) cycle();
    restart = 1'b1;
    cycle();
    restart = 1'b0;
    vectors++;
    if ({os_tick, bit_tick, mid_tick} !== 3'b000) begin
      miscompares++;
      $display("FAIL restart_quiet: got %b, want 000", {os_tick, bit_tick, mid_tick});
    end
    for (int c = 1; c <= 40; c++) begin
      cycle();
      vectors++;
      if ({os_tick, bit_tick, mid_tick} !== {exp_os, exp_bit, exp_mid}) begin
        miscompares++;
        $display("FAIL restart cyc %0d: got %b, want %b", c,
                 {os_tick, bit_tick, mid_tick}, {exp_os, exp_bit, exp_mid});
      end
      if (os_tick) begin
        n++;
        if (first < 0) first = c;
        if (n <= 8) begin
          vectors++;
          if (bit_tick !== (n == 8) || mid_tick !== (n == 4)) begin
            miscompares++;
            $display("FAIL restart_decode tick %0d: got bit=%b mid=%b, want bit=%b mid=%b",
                     n, bit_tick, mid_tick, (n == 8), (n == 4));
          end
        end
      end
    end
    vectors++;
    if (first != 2 || n < 8) begin
      miscompares++;
      $display("FAIL restart_first: got first=%0d ticks=%0d, want first=2 ticks>=8", first, n);
    end
  endtask

  task automatic test_en_hold();
    int n_hold;
    n_hold = 0;
    repeat (10) cycle();
    en = 1'b0;
    for (int c = 0; c < 50; c++) begin
      inc_load = (c == 20); inc_in = 8'd32;
      cycle();
      if (os_tick || bit_tick || mid_tick) n_hold++;
      vectors++;
      if ({os_tick, bit_tick, mid_tick} !== {exp_os, exp_bit, exp_mid} || inc_cur !== exp_inc[7:0]) begin
        miscompares++;
        $display("FAIL en_hold cyc %0d: got %b inc=%0d, want %b inc=%0d", c,
                 {os_tick, bit_tick, mid_tick}, inc_cur, {exp_os, exp_bit, exp_mid}, exp_inc);
      end
    end
    inc_load = 1'b0;
    vectors++;
    if (n_hold != 0 || inc_cur !== 8'd32) begin
      miscompares++;
      $display("FAIL en_hold_summary: got ticks=%0d inc=%0d, want 0 and 32", n_hold, inc_cur);
    end
    en = 1'b1;
    for (int c = 0; c < 40; c++) begin
      cycle();
      vectors++;
      if ({os_tick, bit_tick, mid_tick} !== {exp_os, exp_bit, exp_mid}) begin
        miscompares++;
        $display("FAIL en_resume cyc %0d: got %b, want %b", c,
                 {os_tick, bit_tick, mid_tick}, {exp_os, exp_bit, exp_mid});
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 2000; c++) begin
      en       = ($urandom_range(0, 9) != 0);
      restart  = ($urandom_range(0, 49) == 0);
      inc_load = ($urandom_range(0, 29) == 0);
      inc_in   = 8'($urandom_range(0, 255));
      cycle();
      vectors++;
      if ({os_tick, bit_tick, mid_tick} !== {exp_os, exp_bit, exp_mid} || inc_cur !== exp_inc[7:0]) begin
        miscompares++;
        $display("FAIL random cyc %0d: got %b inc=%0d, want %b inc=%0d", c,
                 {os_tick, bit_tick, mid_tick}, inc_cur, {exp_os, exp_bit, exp_mid}, exp_inc);
      end
    end
    en = 1'b1; restart = 1'b0; inc_load = 1'b0;
  endtask

  task automatic test_reset_mid();
    int n;
    n = 0;
    inc_in = 8'd200; inc_load = 1'b1;
    cycle();
    inc_load = 1'b0;
    repeat (10) cycle();
    rst = 1'b0;
    cycle();
    vectors++;
    if ({os_tick, bit_tick, mid_tick} !== 3'b000 || inc_cur !== 8'(INC8_DEF)) begin
      miscompares++;
      $display("FAIL reset_mid: got ticks=%b inc=%0d, want 000 inc=%0d",
               {os_tick, bit_tick, mid_tick}, inc_cur, INC8_DEF);
    end
    rst = 1'b1; inc_in = 8'd0; inc_load = 1'b1;
    cycle();
    inc_load = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      cycle();
      if (os_tick || bit_tick || mid_tick) n++;
    end
    vectors++;
    if (n != 0 || inc_cur !== 8'd0) begin
      miscompares++;
      $display("FAIL zero_inc: got %0d ticks inc=%0d, want 0 ticks inc=0", n, inc_cur);
    end
  endtask

  initial begin
    test_reset();
    test_default_rate();
    test_rate64();
    test_rate96();
    test_restart();
    test_en_hold();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
